tc_pl_spi_slave: RTL and testbench
==================================

TC_PL_SPI_SLAVE -- requirements
Module: tc_pl_spi_slave

Interface
- REQ-001: Parameter AW, default 7, register address width.
- REQ-002: Parameter DW, default 16, register data width.
- REQ-003: Parameter NREG, default 8, number of writable config registers (NREG <= 2^AW - 1).
- REQ-004: Port clk, input, 1, system clock (125 MHz); the only clock.
- REQ-005: Port rst, input, 1, reset; asynchronous, active-low.
- REQ-006: Port SCK, input, 1, SPI clock from the external master; asynchronous to clk.
- REQ-007: Port CSN, input, 1, SPI chip select, active-low; asynchronous to clk.
- REQ-008: Port SDI, input, 1, SPI master-out data.
- REQ-009: Port SDO, output, 1, SPI master-in data.
- REQ-010: Port stat_in, input, DW, status word returned on reads of address NREG.
- REQ-011: Port cfg_regs, output, NREG*DW, register file, flattened; register k occupies bits [k*DW +: DW].
- REQ-012: Port wr_stb, output, 1, one-clk pulse when a register write commits.
- REQ-013: Port wr_addr, output, AW, address of the last committed write.
- REQ-014: Port frame_err, output, 1, one-clk pulse on an aborted frame.
- REQ-015: Port busy, output, 1, high while CSN (synchronized) is low.

Function
- REQ-016: SCK, CSN and SDI shall each pass a 2-FF synchronizer to clk; edges are detected on the synchronized SCK and CSN; supported SCK frequency is <= clk/8.
- REQ-017: SPI mode 0 (CPOL=0, CPHA=0), MSB first; SDI is sampled on SCK rising edges; SDO updates on SCK falling edges.
- REQ-018: Frame = 1 + AW + DW = 24 bits: bit 23 is R/W (1 = read), bits 22:16 are addr, bits 15:0 are data.
- REQ-019: FSM states: IDLE, CMD, DATA, DONE.
- REQ-020: IDLE -> CMD on CSN falling edge; the bit counter clears to 0.
- REQ-021: CMD -> DATA on the 8th SCK rising edge; R/W and addr are latched at that edge.
- REQ-022: Read: on the CMD->DATA transition, the shift-out register loads cfg_regs[addr] if addr < NREG, stat_in if addr == NREG, else 0. The first data bit appears on SDO at the following SCK falling edge, then one bit per falling edge.
- REQ-023: DATA -> DONE on the 24th SCK rising edge.
- REQ-024: Write commit: on entering DONE with R/W=0 and addr < NREG, cfg_regs[addr] <= data and wr_addr <= addr. wr_stb pulses 1 clk; it is asserted 1 clk after the synchronized 24th rising edge.
- REQ-025: A write to addr >= NREG shall be discarded; no wr_stb, no frame_err.
- REQ-026: A read shall produce no wr_stb and leave cfg_regs unchanged.
- REQ-027: DONE: further SCK edges are ignored and SDO = 0; a frame commits at most once.
- REQ-028: CSN rising edge in any state -> IDLE. If the state was CMD or DATA, frame_err pulses 1 clk and nothing commits.
- REQ-029: CSN falling edge and SCK edge in the same clk: the CSN edge is handled first; that SCK edge is not counted.
- REQ-030: SDO = 0 whenever the state is IDLE, CMD or DONE.
- REQ-031: busy tracks the inverted synchronized CSN; it is independent of the state.

Reset
- REQ-032: While rst = 0, the following hold and remain held until release: state IDLE; bit counter 0; shift registers 0; SDO 0; cfg_regs all 0; wr_stb 0; wr_addr 0; frame_err 0; busy 0; synchronizer flops at idle level (CSN=1, SCK=0, SDI=0).
- REQ-033: Reset asserted mid-frame aborts the frame with no commit. After release, the first frame is accepted only after a fresh CSN falling edge.

Verification
- REQ-034: Write addr 0x03 with 0xA55A at SCK = clk/8 -> exactly one wr_stb; wr_addr = 3; cfg_regs[63:48] = 0xA55A; all other registers 0.
- REQ-035: After REQ-034, read addr 0x03 -> SDO returns 0xA55A MSB-first on data bits 15..0; no wr_stb.
- REQ-036: With stat_in = 0x1234, read addr 0x08 -> 0x1234; read addr 0x7F -> 0x0000.
- REQ-037: Write addr 0x01 with CSN raised after 12 SCK rising edges -> one frame_err pulse; no wr_stb; cfg_regs unchanged. The next complete frame succeeds.
- REQ-038: Frame with 30 SCK cycles (write addr 0x02, data 0xFFFF) -> single wr_stb; register 2 = 0xFFFF; extra bits ignored.
- REQ-039: rst pulsed low mid-DATA of a write -> all outputs at reset values; no wr_stb. With CSN kept low, subsequent SCK pulses do nothing until CSN cycles high then low.

Source files
------------

// File: rtl/tc_pl_spi_slave.sv
// SPI mode-0 slave register file: 24-bit frames {rw, addr, data}, sampled by oversampling SCK/CSN/SDI in the clk domain.
// wr_stb/frame_err fire 1 clk after the synchronized edge that commits/aborts; master must keep SCK <= clk/8.
module tc_pl_spi_slave #(
    parameter int AW   = 7,
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SCK,
    input  logic               CSN,
    input  logic               SDI,
    output logic               SDO,
    input  logic [DW-1:0]      stat_in,
    output logic [NREG*DW-1:0] cfg_regs,
    output logic               wr_stb,
    output logic [AW-1:0]      wr_addr,
    output logic               frame_err,
    output logic               busy
);

    localparam int FW = 1 + AW + DW;
    localparam int CW = $clog2(FW + 1);
    localparam logic [AW-1:0] NREG_A = AW'(NREG);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;

    logic [1:0]    r_sck_s, r_csn_s, r_sdi_s;
    logic          r_sck_d, r_csn_d;
    logic [1:0]    r_live;
    logic          r_armed;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [DW-2:0] r_sin;
    logic [DW-1:0] r_sout;
    logic          r_sdo;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_cfg [NREG];
    logic          r_wr_stb;
    logic [AW-1:0] r_wr_addr;
    logic          r_frame_err;

    logic          w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
    logic [DW-1:0] w_sin_nxt;
    logic [AW-1:0] w_cmd_addr;
    logic          w_cmd_rw;
    logic [DW-1:0] w_rd_dat;
    logic          w_clr, w_inc, w_latch, w_commit, w_abort, w_shout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_s <= 2'b00;
            r_csn_s <= 2'b11;
            r_sdi_s <= 2'b00;
            r_sck_d <= 1'b0;
            r_csn_d <= 1'b1;
            r_live  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sck_s <= {r_sck_s[0], SCK};
            r_csn_s <= {r_csn_s[0], CSN};
            r_sdi_s <= {r_sdi_s[0], SDI};
            r_sck_d <= r_sck_s[1];
            r_csn_d <= r_csn_s[1];
            r_live  <= {r_live[0], 1'b1};
            // A frame may only start after CSN has really been seen high since reset,
            // so a CSN held low across reset cannot look like a fresh falling edge.
            r_armed <= r_armed | (r_live[1] & r_csn_s[1]);
        end
    end

    assign w_sck_rise = r_sck_s[1] & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s[1] & r_sck_d;
    assign w_csn_rise = r_csn_s[1] & ~r_csn_d;
    assign w_csn_fall = r_armed & ~r_csn_s[1] & r_csn_d;

    assign w_sin_nxt  = {r_sin, r_sdi_s[1]};
    assign w_cmd_addr = w_sin_nxt[AW-1:0];
    assign w_cmd_rw   = w_sin_nxt[AW];

    always_comb begin
        w_rd_dat = '0;
        for (int k = 0; k < NREG; k++) begin
            if (w_cmd_addr == AW'(k)) w_rd_dat = r_cfg[k];
        end
        if (w_cmd_addr == NREG_A) w_rd_dat = stat_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        w_shout     = 1'b0;
        if (w_csn_rise) begin
            w_state_nxt = ST_IDLE;
            w_abort     = (r_state == ST_CMD) || (r_state == ST_DATA);
        end else if (w_csn_fall) begin
            w_state_nxt = ST_CMD;
            w_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (w_sck_rise) begin
                        w_inc = 1'b1;
                        if (r_cnt == CW'(AW)) begin
                            w_state_nxt = ST_DATA;
                            w_latch     = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    w_shout = w_sck_fall;
                    if (w_sck_rise) begin
                        w_inc = 1'b1;
                        if (r_cnt == CW'(FW - 1)) begin
                            w_state_nxt = ST_DONE;
                            w_commit    = ~r_rw & (r_addr < NREG_A);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_sin       <= '0;
            r_sout      <= '0;
            r_sdo       <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < NREG; k++) r_cfg[k] <= '0;
        end else begin
            r_wr_stb    <= w_commit;
            r_frame_err <= w_abort;
            if (w_clr) begin
                r_cnt  <= '0;
                r_sin  <= '0;
                r_sout <= '0;
                r_sdo  <= 1'b0;
            end
            if (w_inc) begin
                r_cnt <= r_cnt + 1'b1;
                r_sin <= w_sin_nxt[DW-2:0];
            end
            if (w_latch) begin
                r_rw   <= w_cmd_rw;
                r_addr <= w_cmd_addr;
                r_sout <= w_rd_dat;
                r_sdo  <= 1'b0;
            end
            if (w_shout) begin
                r_sdo  <= r_sout[DW-1];
                r_sout <= {r_sout[DW-2:0], 1'b0};
            end
            if (w_commit) begin
                r_wr_addr <= r_addr;
                for (int k = 0; k < NREG; k++) begin
                    if (r_addr == AW'(k)) r_cfg[k] <= w_sin_nxt;
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign cfg_regs[g*DW +: DW] = r_cfg[g];
    end

    assign SDO       = (r_state == ST_DATA) ? r_sdo : 1'b0;
    assign wr_stb    = r_wr_stb;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;
    assign busy      = ~r_csn_s[1];

endmodule

// File: tb/tb_tc_pl_spi_slave.sv
// Scoreboard bench for tc_pl_spi_slave: a register-file model predicts commits, aborts and read data per frame.
module tb_tc_pl_spi_slave;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int NREG = 8;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_ERR = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [6:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              SCK, CSN, SDI;
    logic              SDO;
    logic [DW-1:0]     stat_in;
    logic [NREG*DW-1:0] cfg_regs;
    logic              wr_stb;
    logic [AW-1:0]     wr_addr;
    logic              frame_err;
    logic              busy;

    ev_t         exp_q[$];
    logic [15:0] obs_q[$];
    logic [15:0] model [NREG];
    int          n_cmp = 0;
    int          n_fail = 0;

    tc_pl_spi_slave #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .SCK(SCK), .CSN(CSN), .SDI(SDI), .SDO(SDO),
        .stat_in(stat_in), .cfg_regs(cfg_regs), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .frame_err(frame_err), .busy(busy)
    );

    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_read(input logic [6:0] a);
        if (a < 7'(NREG)) return model[a[2:0]];
        if (a == 7'(NREG)) return stat_in;
        return 16'h0000;
    endfunction

    task automatic sck_bit(input logic b, output logic so);
        SDI = b;
        tick(4);
        so = SDO;
        SCK = 1'b1;
        tick(4);
        SCK = 1'b0;
    endtask

    task automatic xfer(input logic rw, input logic [6:0] a, input logic [15:0] d,
                        input int nsck, output logic [15:0] rd);
        logic [23:0] f;
        logic so, b;
        f  = {rw, a, d};
        rd = '0;
        CSN = 1'b0;
        tick(4);
        for (int i = 0; i < nsck; i++) begin
            b = (i < 24) ? f[23-i] : 1'($urandom);
            sck_bit(b, so);
            if (i >= 8 && i < 24) rd[23-i] = so;
            if (i < 8)   chk("sdo_in_cmd", so, 0);
            if (i >= 24) chk("sdo_in_done", so, 0);
        end
        tick(4);
        CSN = 1'b1;
        tick(8);
    endtask

    task automatic do_write(input logic [6:0] a, input logic [15:0] d, input int nsck);
        logic [15:0] rd;
        if (nsck < 24) begin
            exp_q.push_back('{kind: K_ERR, addr: a, data: d});
        end else if (a < 7'(NREG)) begin
            exp_q.push_back('{kind: K_WR, addr: a, data: d});
            model[a[2:0]] = d;
        end
        xfer(1'b0, a, d, nsck, rd);
    endtask

    task automatic do_read(input logic [6:0] a, input int nsck);
        logic [15:0] rd;
        exp_q.push_back('{kind: K_RD, addr: a, data: exp_read(a)});
        xfer(1'b1, a, 16'($urandom), nsck, rd);
        obs_q.push_back(rd);
        tick(2);
    endtask

    task automatic check_all(input string name);
        for (int k = 0; k < NREG; k++) chk(name, cfg_regs[k*DW +: DW], model[k]);
    endtask

    initial begin
        ev_t         e;
        logic [15:0] o;
        logic        so;
        int          r;
        logic [6:0]  a;

        rst = 1'b0; SCK = 1'b0; CSN = 1'b1; SDI = 1'b0; stat_in = 16'h0;
        for (int k = 0; k < NREG; k++) model[k] = '0;

        fork
            forever begin
                @(negedge clk);
                if (wr_stb === 1'b1) begin
                    if (exp_q.size() == 0) unexpected("wr_stb");
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_stb_kind", e.kind, K_WR);
                        chk("wr_addr", wr_addr, e.addr);
                        if (e.addr < 7'(NREG)) chk("cfg_after_wr", cfg_regs[e.addr*DW +: DW], e.data);
                    end
                end
                if (frame_err === 1'b1) begin
                    if (exp_q.size() == 0) unexpected("frame_err");
                    else begin
                        e = exp_q.pop_front();
                        chk("frame_err_kind", e.kind, K_ERR);
                    end
                end
                if (obs_q.size() != 0) begin
                    o = obs_q.pop_front();
                    if (exp_q.size() == 0) unexpected("read_data");
                    else begin
                        e = exp_q.pop_front();
                        chk("read_kind", e.kind, K_RD);
                        chk("read_data", o, e.data);
                    end
                end
            end
        join_none

        tick(3);
        chk("rst_sdo", SDO, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cfg", cfg_regs, 0);
        rst = 1'b1;
        tick(6);

        do_write(7'h03, 16'hA55A, 24);
        check_all("cfg_after_first_write");
        do_read(7'h03, 24);
        stat_in = 16'h1234;
        do_read(7'h08, 24);
        do_read(7'h7F, 24);
        do_write(7'h01, 16'hBEEF, 12);
        check_all("cfg_after_abort");
        do_write(7'h01, 16'h1111, 24);
        do_write(7'h02, 16'hFFFF, 30);
        check_all("cfg_after_long_frame");
        do_write(7'h09, 16'h5555, 24);
        do_read(7'h09, 24);
        check_all("cfg_after_discard");

        // Reset mid-DATA of a write with CSN held low across reset.
        CSN = 1'b0;
        tick(4);
        for (int i = 0; i < 15; i++) sck_bit(1'($urandom), so);
        rst = 1'b0;
        tick(3);
        chk("midrst_sdo", SDO, 0);
        chk("midrst_wr_stb", wr_stb, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cfg", cfg_regs, 0);
        for (int k = 0; k < NREG; k++) model[k] = '0;
        rst = 1'b1;
        tick(4);
        chk("postrst_busy", busy, 1);
        for (int i = 0; i < 24; i++) begin
            sck_bit(1'($urandom), so);
            chk("postrst_sdo", so, 0);
        end
        tick(4);
        CSN = 1'b1;
        tick(8);
        check_all("cfg_after_stale_frame");
        do_write(7'h04, 16'h0F0F, 24);
        do_read(7'h04, 24);

        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0:       a = 7'(NREG);
                1:       a = 7'($urandom);
                default: a = 7'($urandom_range(0, NREG - 1));
            endcase
            if (r < 5)       do_write(a, 16'($urandom), $urandom_range(24, 28));
            else if (r < 9) begin
                stat_in = 16'($urandom);
                do_read(a, $urandom_range(24, 27));
            end else         do_write(a, 16'($urandom), $urandom_range(0, 23));
        end

        tick(20);
        chk("scoreboard_drained", 128'(exp_q.size()), 0);
        check_all("cfg_final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
